isqrt_iter: RTL and testbench

//   Parametrised bit-serial integer square root: floor (or round-to-nearest) sqrt of an unsigned WIDTH-bit operand.

---
 rtl/isqrt_pkg.sv | 22 ++
 rtl/isqrt_step.sv | 26 ++
 rtl/isqrt_iter.sv | 122 ++++++++++++
 tb/tb_isqrt_iter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isqrt_pkg.sv
// Shared types and width helpers for the bit-serial integer square root.
package isqrt_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << r) < v) r = r + 1;
    return r;
  endfunction

  function automatic int root_w(input int w);
    return w / 2;
  endfunction

  function automatic int rem_w(input int w);
    return w / 2 + 1;
  endfunction

endpackage

// File: rtl/isqrt_step.sv
// One restoring square-root iteration: brings down an operand bit pair and
// resolves one root bit.
module isqrt_step #(
  parameter int N = 16
) (
  input  logic [N+1:0] i_r,
  input  logic [N-1:0] i_q,
  input  logic [1:0]   i_pair,
  output logic [N+1:0] o_r,
  output logic [N-1:0] o_q
);

  logic [N+3:0] w_cat;
  logic [N+3:0] w_sub;
  logic [N+1:0] w_t;
  logic         w_ge;

  assign w_cat = {i_r, i_pair};
  assign w_sub = {2'b00, i_q, 2'b01};
  assign w_ge  = (w_cat >= w_sub);
  // The partial remainder stays <= 2q, so the narrow difference never wraps.
  assign w_t   = w_cat[N+1:0] - w_sub[N+1:0];
  assign o_r   = w_ge ? w_t : w_cat[N+1:0];
  assign o_q   = {i_q[N-2:0], w_ge};

endmodule

// File: rtl/isqrt_iter.sv
// Bit-serial integer square root with valid/ready on both sides.
// Define ISQRT_REM_EN to export the floor remainder on port rem.
module isqrt_iter
  import isqrt_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int ROUND = 0,
  localparam int N     = root_w(WIDTH),
  localparam int KW    = clog2(N)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] xin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     result,
  output logic             busy
`ifdef ISQRT_REM_EN
  ,
  output logic [N:0]       rem
`endif
);

  state_t           r_state;
  logic [WIDTH-1:0] r_x;
  logic [N+1:0]     r_rem;
  logic [N-1:0]     r_q;
  logic [KW-1:0]    r_k;
  logic [N-1:0]     r_result;
  logic             r_out_valid;
  logic             r_busy;
  logic             r_rdy_en;
`ifdef ISQRT_REM_EN
  logic [N:0]       r_rem_out;
`endif

  logic [N+1:0]     w_r;
  logic [N-1:0]     w_q;
  logic [N-1:0]     w_res;
  logic             w_accept;

  isqrt_step #(.N(N)) u_step (
    .i_r    (r_rem),
    .i_q    (r_q),
    .i_pair (r_x[WIDTH-1:WIDTH-2]),
    .o_r    (w_r),
    .o_q    (w_q)
  );

  // Round up when x > q^2 + q; an all-ones root cannot go higher.
  always_comb begin
    w_res = w_q;
    if ((ROUND != 0) && (w_r > {2'b00, w_q}) && (w_q != '1))
      w_res = w_q + N'(1);
  end

  // r_rdy_en keeps in_ready low during reset and until the first edge after it.
  assign in_ready  = r_rdy_en & ((r_state == IDLE) | ((r_state == DONE) & out_ready));
  assign w_accept  = in_valid & in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign result    = r_result;
`ifdef ISQRT_REM_EN
  assign rem       = r_rem_out;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_x         <= '0;
      r_rem       <= '0;
      r_q         <= '0;
      r_k         <= '0;
      r_result    <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_rdy_en    <= 1'b0;
`ifdef ISQRT_REM_EN
      r_rem_out   <= '0;
`endif
    end else begin
      r_rdy_en <= 1'b1;
      if (w_accept) begin
        r_x         <= xin;
        r_rem       <= '0;
        r_q         <= '0;
        r_k         <= KW'(N - 1);
        r_state     <= CALC;
        r_busy      <= 1'b1;
        r_out_valid <= 1'b0;
      end else begin
        case (r_state)
          CALC: begin
            r_x   <= {r_x[WIDTH-3:0], 2'b00};
            r_rem <= w_r;
            r_q   <= w_q;
            r_k   <= r_k - KW'(1);
            if (r_k == '0) begin
              r_state     <= DONE;
              r_busy      <= 1'b0;
              r_out_valid <= 1'b1;
              r_result    <= w_res;
`ifdef ISQRT_REM_EN
              r_rem_out   <= w_r[N:0];
`endif
            end
          end
          DONE: begin
            if (out_ready) begin
              r_out_valid <= 1'b0;
              r_state     <= IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_isqrt_iter.sv
// Scoreboard bench for isqrt_iter: 32-bit floor and round instances share
// stimulus, an 8-bit floor instance is swept exhaustively.
module tb_isqrt_iter;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic        iv32, or32;
  logic [31:0] x32;
  logic        ir32f, ir32r, ov32f, ov32r, busy32f, busy32r;
  logic [15:0] res32f, res32r;
  logic        iv8, or8;
  logic [7:0]  x8;
  logic        ir8, ov8, busy8;
  logic [3:0]  res8;
`ifdef ISQRT_REM_EN
  logic [16:0] rem32f, rem32r;
  logic [4:0]  rem8;
`endif

  isqrt_iter #(.WIDTH(32), .ROUND(0)) u32f (
    .clk(clk), .rstn(rstn), .in_valid(iv32), .in_ready(ir32f), .xin(x32),
    .out_valid(ov32f), .out_ready(or32), .result(res32f), .busy(busy32f)
`ifdef ISQRT_REM_EN
    , .rem(rem32f)
`endif
  );

  isqrt_iter #(.WIDTH(32), .ROUND(1)) u32r (
    .clk(clk), .rstn(rstn), .in_valid(iv32), .in_ready(ir32r), .xin(x32),
    .out_valid(ov32r), .out_ready(or32), .result(res32r), .busy(busy32r)
`ifdef ISQRT_REM_EN
    , .rem(rem32r)
`endif
  );

  isqrt_iter #(.WIDTH(8), .ROUND(0)) u8 (
    .clk(clk), .rstn(rstn), .in_valid(iv8), .in_ready(ir8), .xin(x8),
    .out_valid(ov8), .out_ready(or8), .result(res8), .busy(busy8)
`ifdef ISQRT_REM_EN
    , .rem(rem8)
`endif
  );

  typedef struct {
    longint x;
    longint f;
    longint r;
    longint rm;
  } exp_t;

  exp_t   q32[$];
  exp_t   q8[$];
  exp_t   nxt32, nxt8;
  int     total = 0;
  int     bad   = 0;
  longint cyc   = 0;
  longint acc32 = 0, acc8 = 0;
  bit     pv32 = 0, pv8 = 0;
  bit     a32, a8;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference by trial squaring: largest f with f*f <= x.
  function automatic exp_t mk(input longint x, input int n);
    exp_t   e;
    longint f, t;
    f = 0;
    for (int b = n - 1; b >= 0; b--) begin
      t = f | (longint'(1) << b);
      if (t * t <= x) f = t;
    end
    e.x  = x;
    e.f  = f;
    e.rm = x - f * f;
    e.r  = (e.rm > f && f != ((longint'(1) << n) - 1)) ? f + 1 : f;
    return e;
  endfunction

  // Evaluate both handshakes just before the next rising edge, then advance.
  task automatic step();
    exp_t e;
    #1;
    a32 = 0;
    a8  = 0;
    if (ov32f && !pv32) chk("lat32", cyc - acc32, 16);
    if (ov32f && or32) begin
      if (q32.size() == 0) chk("spurious32", 1, 0);
      else begin
        e = q32.pop_front();
        chk("res32_floor", res32f, e.f);
        chk("res32_round", res32r, e.r);
        chk("ov32_round", ov32r, 1);
`ifdef ISQRT_REM_EN
        chk("rem32_floor", rem32f, e.rm);
        chk("rem32_round", rem32r, e.rm);
`endif
      end
    end
    pv32 = ov32f;
    if (iv32 && ir32f) begin
      q32.push_back(nxt32);
      acc32 = cyc + 1;
      a32 = 1;
    end
    if (ov8 && !pv8) chk("lat8", cyc - acc8, 4);
    if (ov8 && or8) begin
      if (q8.size() == 0) chk("spurious8", 1, 0);
      else begin
        e = q8.pop_front();
        chk("res8", res8, e.f);
`ifdef ISQRT_REM_EN
        chk("rem8", rem8, e.rm);
`endif
      end
    end
    pv8 = ov8;
    if (iv8 && ir8) begin
      q8.push_back(nxt8);
      acc8 = cyc + 1;
      a8 = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send32(input longint x, input longint f, input longint r, input longint rm);
    int n;
    nxt32 = '{x, f, r, rm};
    x32 = x[31:0];
    iv32 = 1;
    n = 0;
    do begin
      step();
      n++;
    end while (!a32 && n < 60);
    if (!a32) chk("accept32_timeout", 0, 1);
    iv32 = 0;
    x32 = $urandom;
  endtask

  task automatic wait_out32();
    int n;
    n = 0;
    while (!ov32f && n < 60) begin
      step();
      n++;
    end
    if (!ov32f) chk("out32_timeout", 0, 1);
  endtask

  task automatic recv32();
    wait_out32();
    or32 = 1;
    step();
    or32 = 0;
  endtask

  initial begin
    int     sent, guard, sel;
    longint v, s;
    logic [15:0] hold;

    iv32 = 0; or32 = 0; x32 = 0;
    iv8 = 0;  or8 = 0;  x8 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ir32", ir32f, 0);
    chk("rst_ov32", ov32f, 0);
    chk("rst_busy32", busy32f, 0);
    chk("rst_res32", res32f, 0);
    chk("rst_ir8", ir8, 0);
`ifdef ISQRT_REM_EN
    chk("rst_rem32", rem32f, 0);
`endif
    rstn = 1;
    #1;
    chk("ir_before_edge", ir32f, 0);
    @(posedge clk);
    #1;
    chk("ir_after_edge", ir32f, 1);

    send32(144, 12, 12, 0);
    chk("busy_calc", busy32f, 1);
    chk("ir_calc", ir32f, 0);
    recv32();

    // Back-pressure: result held while a new operand waits upstream.
    send32(150, 12, 12, 6);
    wait_out32();
    nxt32 = '{81, 9, 9, 0};
    x32 = 32'd81;
    iv32 = 1;
    repeat (5) begin
      step();
      chk("bp_res", res32f, 12);
      chk("bp_res_round", res32r, 12);
      chk("bp_ov", ov32f, 1);
      chk("bp_ir", ir32f, 0);
`ifdef ISQRT_REM_EN
      chk("bp_rem", rem32f, 6);
`endif
    end
    or32 = 1;
    step();
    chk("zero_bubble_accept", a32, 1);
    iv32 = 0;
    or32 = 0;
    recv32();

    send32(0, 0, 0, 0);
    recv32();
    send32(157, 12, 13, 13);
    recv32();
    send32(64'hFFFF_FFFF, 65535, 65535, 131070);
    recv32();

    // Reset while k=7: the operand must vanish without a result.
    send32(1000, 31, 32, 39);
    repeat (8) step();
    chk("busy_before_abort", busy32f, 1);
    rstn = 0;
    #1;
    q32.delete();
    pv32 = 0;
    chk("abort_ir", ir32f, 0);
    chk("abort_ov", ov32f, 0);
    chk("abort_busy", busy32f, 0);
    chk("abort_res", res32f, 0);
    repeat (3) step();
    rstn = 1;
    #1;
    chk("abort_ir_release", ir32f, 0);
    step();
    chk("abort_ir_ready", ir32f, 1);
    repeat (20) step();
    send32(49, 7, 7, 0);
    recv32();

    // 8-bit instance: all operands with random valid/ready gaps.
    sent = 255;
    guard = 0;
    while ((sent < 511 || q8.size() > 0 || iv8) && guard < 20000) begin
      if (!iv8 && sent < 511 && $urandom_range(0, 3) != 0) begin
        v = longint'(sent % 256);
        x8 = v[7:0];
        nxt8 = mk(v, 4);
        iv8 = 1;
      end
      or8 = ($urandom_range(0, 2) != 0);
      step();
      if (a8) begin
        iv8 = 0;
        sent++;
      end
      guard++;
    end
    chk("drain8", q8.size(), 0);
    or8 = 0;

    // 32-bit instances: random operands biased towards squares and rounding edges.
    sent = 0;
    guard = 0;
    while ((sent < 300 || q32.size() > 0 || iv32) && guard < 30000) begin
      if (!iv32 && sent < 300 && $urandom_range(0, 2) != 0) begin
        s = longint'($urandom_range(0, 65535));
        sel = $urandom_range(0, 3);
        case (sel)
          0:       v = longint'($urandom);
          1:       v = s * s;
          2:       v = (s * s - 1) & 64'hFFFF_FFFF;
          default: v = (s * s + s) & 64'hFFFF_FFFF;
        endcase
        x32 = v[31:0];
        nxt32 = mk(v, 16);
        iv32 = 1;
      end
      or32 = ($urandom_range(0, 3) != 0);
      step();
      if (a32) begin
        iv32 = 0;
        sent++;
      end
      guard++;
    end
    chk("drain32", q32.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
